// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 sequencing controller: steps each instruction through fetch/decode/execute/memory/writeback
// and drives the shared datapath's mux selects and enables, with memory-timeout and illegal-opcode detection.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        WB_MEM   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        WB_R     = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            mem_access;
    logic            set_illegal;
    logic            set_bus_error;
    logic            next_instr_state_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (set_illegal)   illegal_instr <= 1'b1;
            if (set_bus_error) bus_error     <= 1'b1;
        end
    end

    always_comb begin
        state_next           = state_reg;
        wait_cnt_next        = '0;
        mem_access           = 1'b0;
        set_illegal          = 1'b0;
        set_bus_error        = 1'b0;
        next_instr_state_sel = 1'b0;
        mem_read             = 1'b0;
        mem_write            = 1'b0;
        i_or_d               = 1'b0;
        ir_write             = 1'b0;
        pc_write             = 1'b0;
        pc_write_cond        = 1'b0;
        pc_source            = 1'b0;
        alu_src_a            = 1'b0;
        alu_src_b            = 2'b00;
        alu_op               = 2'b00;
        reg_write            = 1'b0;
        mem_to_reg           = 1'b0;
        instr_done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                mem_access = 1'b1;
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                // Branch target is precomputed here so BRANCH only needs the compare.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:          state_next = EXEC_R;
                    OP_LOAD, OP_STORE: state_next = MEM_ADDR;
                    OP_BRANCH:         state_next = BRANCH;
                    default: begin
                        state_next  = HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = WB_R;
            end
            WB_R: begin
                reg_write            = 1'b1;
                instr_done           = 1'b1;
                next_instr_state_sel = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_access = 1'b1;
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                if (mem_ready) state_next = WB_MEM;
            end
            WB_MEM: begin
                reg_write            = 1'b1;
                mem_to_reg           = 1'b1;
                instr_done           = 1'b1;
                next_instr_state_sel = 1'b1;
            end
            MEM_WR: begin
                mem_access           = 1'b1;
                mem_write            = 1'b1;
                i_or_d               = 1'b1;
                instr_done           = mem_ready;
                next_instr_state_sel = mem_ready;
            end
            BRANCH: begin
                alu_src_a            = 1'b1;
                alu_op               = 2'b01;
                pc_write_cond        = 1'b1;
                pc_source            = 1'b1;
                instr_done           = 1'b1;
                next_instr_state_sel = 1'b1;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (next_instr_state_sel) state_next = run ? FETCH : IDLE;

        // The counter is zero on any cycle that is not a continuing wait, which covers entry into an access.
        if (mem_access && !mem_ready) begin
            if (wait_cnt_reg == WAIT_LAST) begin
                state_next    = HALT;
                set_bus_error = 1'b1;
            end else begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
            end
        end
    end

    assign state_dbg = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver queues the expected per-cycle output word,
// the monitor pops and compares it on the falling edge.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0010011;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                           S_MEM_RD = 4'd4, S_WB_MEM = 4'd5, S_MEM_WR = 4'd6, S_EXEC_R = 4'd7,
                           S_WB_R = 4'd8, S_BRANCH = 4'd9, S_HALT = 4'd15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, instr_done, illegal_instr, bus_error;
    logic [3:0] state_dbg;

    int checks = 0;
    int failures = 0;
    int vec_idx = 0;
    logic [20:0] exp_q[$];
    logic [20:0] act;

    multicycle_control_fsm #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done,
                  illegal_instr, bus_error, state_dbg};

    // Expected output word for a state, from the per-state output table.
    function automatic logic [20:0] expect_vec(input logic [3:0] st, input logic mr,
                                               input logic ill, input logic be);
        logic rd, wr, iod, irw, pcw, pcc, pcs, sa, rw, m2r, dn;
        logic [1:0] sb, op;
        {rd, wr, iod, irw, pcw, pcc, pcs, sa, rw, m2r, dn} = '0;
        sb = 2'b00;
        op = 2'b00;
        case (st)
            S_FETCH:    begin rd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:   begin sb = 2'b11; end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; end
            S_MEM_RD:   begin rd = 1; iod = 1; end
            S_WB_MEM:   begin rw = 1; m2r = 1; dn = 1; end
            S_MEM_WR:   begin wr = 1; iod = 1; dn = mr; end
            S_EXEC_R:   begin sa = 1; op = 2'b10; end
            S_WB_R:     begin rw = 1; dn = 1; end
            S_BRANCH:   begin sa = 1; op = 2'b01; pcc = 1; pcs = 1; dn = 1; end
            default:    ;
        endcase
        return {rd, wr, iod, irw, pcw, pcc, pcs, sa, sb, op, rw, m2r, dn, ill, be, st};
    endfunction

    task automatic step(input logic rst, input logic r, input logic [6:0] op, input logic mr,
                        input logic [3:0] st, input logic ill, input logic be);
        @(posedge clk);
        #1;
        reset = rst;
        run = r;
        opcode = op;
        mem_ready = mr;
        exp_q.push_back(expect_vec(st, mr, ill, be));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            e = exp_q.pop_front();
            checks++;
            vec_idx++;
            if (act !== e) begin
                failures++;
                $display("FAIL vec%0d got=%h (state=%0d) required=%h (state=%0d)",
                         vec_idx, act, act[3:0], e, e[3:0]);
            end else begin
                $display("vec%0d ok state=%0d out=%h", vec_idx, act[3:0], act);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        step(1, 0, R, 0, S_IDLE, 0, 0);
        step(1, 1, R, 1, S_IDLE, 0, 0);
        // R-type, zero wait
        step(0, 1, R, 1, S_IDLE, 0, 0);
        step(0, 1, R, 1, S_FETCH, 0, 0);
        step(0, 1, R, 1, S_DECODE, 0, 0);
        step(0, 1, R, 1, S_EXEC_R, 0, 0);
        step(0, 1, R, 1, S_WB_R, 0, 0);
        // lw with two wait cycles
        step(0, 1, LW, 1, S_FETCH, 0, 0);
        step(0, 1, LW, 1, S_DECODE, 0, 0);
        step(0, 1, LW, 1, S_MEM_ADDR, 0, 0);
        step(0, 1, LW, 0, S_MEM_RD, 0, 0);
        step(0, 1, LW, 0, S_MEM_RD, 0, 0);
        step(0, 1, LW, 1, S_MEM_RD, 0, 0);
        step(0, 1, LW, 1, S_WB_MEM, 0, 0);
        // sw then beq
        step(0, 1, SW, 1, S_FETCH, 0, 0);
        step(0, 1, SW, 1, S_DECODE, 0, 0);
        step(0, 1, SW, 1, S_MEM_ADDR, 0, 0);
        step(0, 1, SW, 1, S_MEM_WR, 0, 0);
        step(0, 1, BEQ, 1, S_FETCH, 0, 0);
        step(0, 1, BEQ, 1, S_DECODE, 0, 0);
        step(0, 1, BEQ, 1, S_BRANCH, 0, 0);
        // R-type with run dropped mid-instruction
        step(0, 1, R, 1, S_FETCH, 0, 0);
        step(0, 0, R, 1, S_DECODE, 0, 0);
        step(0, 0, R, 1, S_EXEC_R, 0, 0);
        step(0, 0, R, 1, S_WB_R, 0, 0);
        step(0, 0, R, 1, S_IDLE, 0, 0);
        // fetch ready on the last allowed cycle, then illegal opcode
        step(0, 1, BAD, 0, S_IDLE, 0, 0);
        step(0, 1, BAD, 0, S_FETCH, 0, 0);
        step(0, 1, BAD, 0, S_FETCH, 0, 0);
        step(0, 1, BAD, 0, S_FETCH, 0, 0);
        step(0, 1, BAD, 1, S_FETCH, 0, 0);
        step(0, 1, BAD, 1, S_DECODE, 0, 0);
        step(0, 1, R, 1, S_HALT, 1, 0);
        step(0, 1, R, 1, S_HALT, 1, 0);
        step(1, 1, R, 1, S_IDLE, 0, 0);
        // fetch timeout
        step(0, 1, R, 0, S_IDLE, 0, 0);
        step(0, 1, R, 0, S_FETCH, 0, 0);
        step(0, 1, R, 0, S_FETCH, 0, 0);
        step(0, 1, R, 0, S_FETCH, 0, 0);
        step(0, 1, R, 0, S_FETCH, 0, 0);
        step(0, 1, R, 1, S_HALT, 0, 1);
        step(0, 1, R, 1, S_HALT, 0, 1);
        // async reset in the middle of a store
        step(1, 0, SW, 1, S_IDLE, 0, 0);
        step(0, 1, SW, 1, S_IDLE, 0, 0);
        step(0, 1, SW, 1, S_FETCH, 0, 0);
        step(0, 1, SW, 1, S_DECODE, 0, 0);
        step(0, 1, SW, 1, S_MEM_ADDR, 0, 0);
        step(0, 1, SW, 0, S_MEM_WR, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL async_reset got mem_write=%0b state=%0d required mem_write=0 state=0",
                     mem_write, state_dbg);
        end else begin
            $display("async_reset ok mem_write=%0b state=%0d", mem_write, state_dbg);
        end
        step(1, 0, SW, 0, S_IDLE, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the RV32 core. It replaces single-cycle opcode decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback over several cycles, so one ALU and one unified memory port are shared. It drives the datapath muxes and enables, and handshakes with memory through a ready signal. It also detects memory timeouts and unsupported opcodes.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive wait cycles tolerated on a memory access before a bus error (must be >= 1)
TO_W, 5, width of the wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  core clock, all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  core enable, sampled only at instruction boundaries
opcode  in  7  instruction register bits [6:0], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
mem_read  out  1  memory read request (fetch or load)
mem_write  out  1  memory write request (store)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  latch fetched word into IR
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update qualified by ALU zero (beq)
pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut
alu_src_a  out  1  ALU A: 0 = PC, 1 = rs1
alu_src_b  out  2  ALU B: 00 = rs2, 01 = constant 4, 10 = I/S immediate, 11 = B immediate
alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction
illegal_instr  out  1  sticky: unsupported opcode decoded
bus_error  out  1  sticky: memory timeout
state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, WB_MEM=5, MEM_WR=6, EXEC_R=7, WB_R=8, BRANCH=9, HALT=15.
- Registered state. All outputs except the sticky flags are decoded from the state (Moore), plus mem_ready where noted. Any output not listed for a state is 0.
- Reset (async, at any time, including mid-access): state=IDLE, wait counter=0, illegal_instr=0, bus_error=0. All outputs are 0 while in reset.
- IDLE: all outputs 0. Next state is FETCH if run=1, otherwise stay.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write and pc_write equal mem_ready. On mem_ready, next state is DECODE; otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - other → HALT, setting illegal_instr
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next state WB_R.
- WB_R: reg_write=1, mem_to_reg=0, instr_done=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_RD for a load, MEM_WR for a store. The opcode must remain stable (IR is not rewritten).
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready, next state is WB_MEM; otherwise hold.
- WB_MEM: reg_write=1, mem_to_reg=1, instr_done=1.
- MEM_WR: mem_write=1, i_or_d=1. instr_done equals mem_ready. On mem_ready the instruction completes.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1.
- Instruction completion (WB_R, WB_MEM, BRANCH, MEM_WR with mem_ready): next state is FETCH if run=1, otherwise IDLE.
- Minimum latency with zero wait states: beq 3 cycles, R-type 4, sw 4, lw 5.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR, and whenever mem_ready=1.
  - Increments on each cycle in those states with mem_ready=0.
  - If the counter equals MEM_TIMEOUT-1 while mem_ready=0, next state is HALT and bus_error is set.
  - mem_ready arriving on that same cycle takes priority: normal transition, no error.
- HALT: all outputs 0 except the sticky flags. It is left only by reset; run is ignored.
- mem_ready is ignored in states that make no memory request.

Test Plan:
- Reset, run=1, opcode=0110011, mem_ready=1 always → state_dbg sequence 1,2,7,8,1. reg_write=1 only in cycle 4 with mem_to_reg=0. instr_done pulses in cycle 4.
- lw (0000011) with mem_ready low for 2 cycles in MEM_RD → states 1,2,3,4,4,4,5. mem_read and i_or_d=1 held for 3 cycles. reg_write and mem_to_reg=1 in WB_MEM.
- sw (0100011) then beq (1100011), zero wait states → sw takes 4 cycles with mem_write=1 in cycle 4. beq takes 3 cycles with pc_write_cond=1 and pc_source=1 in cycle 3. Exactly two instr_done pulses.
- opcode=0010011 at DECODE → HALT (15), illegal_instr=1. Stays halted despite run and mem_ready. Reset clears to IDLE with illegal_instr=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT after 4 FETCH cycles, bus_error=1. Repeat with mem_ready=1 on the 4th cycle → DECODE, no error.
- run dropped during an R-type → instruction completes, then IDLE with outputs 0. Async reset asserted mid-MEM_WR → mem_write deasserts immediately, not waiting for a clock edge.
